// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes and the
// datapath select encodings also used by the datapath and ALU control.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StAluWb   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12,
    StIllegal = 4'd13
  } mc_state_e;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  // alu_op encodings (3 is reserved)
  localparam logic [1:0] AluOpAdd   = 2'd0;
  localparam logic [1:0] AluOpSub   = 2'd1;
  localparam logic [1:0] AluOpFunct = 2'd2;

  // pc_source encodings
  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] SrcBRegB   = 2'd0;
  localparam logic [1:0] SrcBFour   = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh2 = 2'd3;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer: counts cycles a request is outstanding without ready and flags
// expiry on the cycle the MAX_WAIT-th such cycle completes.
module mc_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority so a completed or abandoned access never leaks count forward
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == CntLast);

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle MIPS datapath over one unified memory.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap and halt on illegal opcodes;
// otherwise an illegal opcode retires as a NOP.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_ne,
  output logic [1:0]           pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 trap
);

  mc_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 timeout_q, timeout_d;
  logic                 bne_q, bne_d;
  logic                 retire;
  logic                 timer_expired;

  // Counting only while a request is stalled; any other cycle restarts the wait
  mc_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clear_i   (!mem_req || mem_ready || timer_expired),
    .enable_i  (mem_req && !mem_ready),
    .expired_o (timer_expired)
  );

  // Next-state, retire and sticky-flag logic
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    // Branch sense is latched in DECODE so BRANCH outputs depend on state only
    bne_d   = (state_q == StDecode) ? opcode[0] : bne_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpAddi:      state_d = StAddiEx;
          OpJ:         state_d = StJump;
          default:     state_d = StIllegal;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StIllegal: begin
`ifdef MC_ILLEGAL_TRAP_EN
        state_d = StIllegal;
`else
        state_d = StFetch;
        retire  = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
    if (timer_expired) begin
      state_d = StIdle;
      retire  = 1'b0;
    end
    timeout_d = timeout_q || timer_expired;
    instret_d = instret_q + CNT_WIDTH'(retire);
  end

  // FSM and architectural counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      instret_q <= '0;
      timeout_q <= 1'b0;
      bne_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      timeout_q <= timeout_d;
      bne_q     <= bne_d;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;

  // Trap raises on entry to ILLEGAL and holds until reset
  always_comb begin
    trap_d = trap_q || (state_d == StIllegal);
  end

  // Trap flag state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign mem_timeout = timeout_q;
  assign instret     = instret_q;

  // Output decode of the current state; only FETCH load strobes look at mem_ready
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PcSrcAlu;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBRegB;
    alu_op        = AluOpAdd;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: alu_src_b = SrcBImmSh2;
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StAddiWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = AluOpSub;
        pc_write_cond = 1'b1;
        pc_source     = PcSrcAluOut;
        branch_ne     = bne_q;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PcSrcJump;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Vector-table bench for multicycle_control with a queue scoreboard of expected outputs.
module tb_multicycle_control;

  typedef enum int {
    Idle, Fetch, Decode, MemAdr, MemRd, MemWb, MemWr, Exec, AluWb,
    AddiEx, AddiWb, BranchEq, BranchNe, Jump, Illegal
  } tst_e;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [16:0] ctl;
    logic [31:0] ir;
    logic        tmo;
    logic        trp;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, mem_timeout, trap;
  logic [31:0] instret;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs[$];
  vec_t sb[$];

  multicycle_control #(
    .MAX_WAIT  (16),
    .CNT_WIDTH (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .mem_timeout   (mem_timeout),
    .instret       (instret),
    .trap          (trap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [16:0] cw(
    input logic req, we, io, irw, pcw, pcwc, bne,
    input logic [1:0] psrc, input logic sa, input logic [1:0] sbx, input logic [1:0] aop,
    input logic rdst, m2r, rw);
    return {req, we, io, irw, pcw, pcwc, bne, psrc, sa, sbx, aop, rdst, m2r, rw};
  endfunction

  // Expected control word per state, straight from the state output table
  function automatic logic [16:0] exp_ctl(input tst_e s, input logic r);
    case (s)
      Fetch:    return cw(1, 0, 0, r, r, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0, 0, 0);
      Decode:   return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 2'd0, 0, 0, 0);
      MemAdr:   return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0, 0, 0);
      MemRd:    return cw(1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
      MemWb:    return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1);
      MemWr:    return cw(1, 1, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
      Exec:     return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 0, 0, 0);
      AluWb:    return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 1);
      AddiEx:   return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0, 0, 0);
      AddiWb:   return cw(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 1);
      BranchEq: return cw(0, 0, 0, 0, 0, 1, 0, 2'd1, 1, 2'd0, 2'd1, 0, 0, 0);
      BranchNe: return cw(0, 0, 0, 0, 0, 1, 1, 2'd1, 1, 2'd0, 2'd1, 0, 0, 0);
      Jump:     return cw(0, 0, 0, 0, 1, 0, 0, 2'd2, 0, 2'd0, 2'd0, 0, 0, 0);
      default:  return '0;
    endcase
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input tst_e s,
                     input int ir, input logic tmo, input logic trp);
    vec_t v;
    v.rst_n = r;
    v.op    = op;
    v.rdy   = rdy;
    v.ctl   = exp_ctl(s, rdy);
    v.ir    = ir;
    v.tmo   = tmo;
    v.trp   = trp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec %0d got %h want %h", name, idx, got, want);
  endtask

  logic [16:0] act_ctl;
  assign act_ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                    pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write};

  initial begin
    vec_t e;
    reset     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b0;

    // R-type with immediate ready
    add(0, 6'h00, 0, Idle,   0, 0, 0);
    add(1, 6'h00, 0, Idle,   0, 0, 0);
    add(1, 6'h00, 1, Fetch,  0, 0, 0);
    add(1, 6'h00, 1, Decode, 0, 0, 0);
    add(1, 6'h00, 1, Exec,   0, 0, 0);
    add(1, 6'h00, 1, AluWb,  0, 0, 0);
    // lw with three wait cycles in FETCH and MEMRD
    for (int i = 0; i < 3; i++) add(1, 6'h23, 0, Fetch, 1, 0, 0);
    add(1, 6'h23, 1, Fetch,  1, 0, 0);
    add(1, 6'h23, 0, Decode, 1, 0, 0);
    add(1, 6'h23, 0, MemAdr, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 6'h23, 0, MemRd, 1, 0, 0);
    add(1, 6'h23, 1, MemRd,  1, 0, 0);
    add(1, 6'h23, 0, MemWb,  1, 0, 0);
    // bne, beq, addi, j
    add(1, 6'h05, 1, Fetch,    2, 0, 0);
    add(1, 6'h05, 0, Decode,   2, 0, 0);
    add(1, 6'h05, 0, BranchNe, 2, 0, 0);
    add(1, 6'h04, 1, Fetch,    3, 0, 0);
    add(1, 6'h04, 0, Decode,   3, 0, 0);
    add(1, 6'h04, 0, BranchEq, 3, 0, 0);
    add(1, 6'h08, 1, Fetch,    4, 0, 0);
    add(1, 6'h08, 0, Decode,   4, 0, 0);
    add(1, 6'h08, 0, AddiEx,   4, 0, 0);
    add(1, 6'h08, 0, AddiWb,   4, 0, 0);
    add(1, 6'h02, 1, Fetch,    5, 0, 0);
    add(1, 6'h02, 0, Decode,   5, 0, 0);
    add(1, 6'h02, 0, Jump,     5, 0, 0);
    // illegal opcode
    add(1, 6'h3F, 1, Fetch,    6, 0, 0);
    add(1, 6'h3F, 0, Decode,   6, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    add(1, 6'h3F, 1, Illegal,  6, 0, 1);
    add(1, 6'h3F, 1, Illegal,  6, 0, 1);
    add(1, 6'h00, 1, Illegal,  6, 0, 1);
`else
    add(1, 6'h3F, 0, Illegal,  6, 0, 0);
    add(1, 6'h00, 0, Fetch,    7, 0, 0);
`endif
    // sw that never completes: timeout after 16 stalled cycles
    add(0, 6'h00, 0, Idle,   0, 0, 0);
    add(1, 6'h2B, 0, Idle,   0, 0, 0);
    add(1, 6'h2B, 1, Fetch,  0, 0, 0);
    add(1, 6'h2B, 0, Decode, 0, 0, 0);
    add(1, 6'h2B, 0, MemAdr, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 6'h2B, 0, MemWr, 0, 0, 0);
    add(1, 6'h2B, 1, Idle,   0, 1, 0);
    // recovery keeps the sticky timeout flag
    add(1, 6'h00, 1, Fetch,  0, 1, 0);
    add(1, 6'h00, 0, Decode, 0, 1, 0);
    add(1, 6'h00, 0, Exec,   0, 1, 0);
    add(1, 6'h00, 0, AluWb,  0, 1, 0);
    add(1, 6'h2B, 1, Fetch,  1, 1, 0);
    add(1, 6'h2B, 0, Decode, 1, 1, 0);
    add(1, 6'h2B, 0, MemAdr, 1, 1, 0);
    add(1, 6'h2B, 1, MemWr,  1, 1, 0);
    // reset mid-MEMWR
    add(1, 6'h2B, 1, Fetch,  2, 1, 0);
    add(1, 6'h2B, 0, Decode, 2, 1, 0);
    add(1, 6'h2B, 0, MemAdr, 2, 1, 0);
    add(1, 6'h2B, 0, MemWr,  2, 1, 0);
    add(0, 6'h2B, 0, Idle,   0, 0, 0);
    add(1, 6'h2B, 0, Idle,   0, 0, 0);
    add(1, 6'h2B, 0, Fetch,  0, 0, 0);

    @(posedge clock);
    #1;
    foreach (vecs[i]) begin
      reset     = vecs[i].rst_n;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i]);
      @(negedge clock);
      e = sb.pop_front();
      check("ctl",     i, 32'(act_ctl),     32'(e.ctl));
      check("instret", i, instret,          e.ir);
      check("timeout", i, 32'(mem_timeout), 32'(e.tmo));
      check("trap",    i, 32'(trap),        32'(e.trp));
      @(posedge clock);
      #1;
    end

    // Asynchronous reset between clock edges while requesting in FETCH
    check("req_before_rst", -1, 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("req_async_rst", -1, 32'(mem_req), 32'd0);
    check("ctl_async_rst", -1, 32'(act_ctl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
